// File: rtl/detectfaces_div_pkg.sv
// Shared widths and state encoding for the face-detection sequential divider.
package detectfaces_div_pkg;
   localparam int DIVIDEND_WIDTH = 25;
   localparam int DIVISOR_WIDTH  = 10;
   localparam int QUOTIENT_WIDTH = 16;
   localparam int CNT_WIDTH      = $clog2(DIVIDEND_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;
endpackage

// File: rtl/detectfaces_udiv_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor when it fits.
module detectfaces_udiv_step #(
   parameter int DW = detectfaces_div_pkg::DIVISOR_WIDTH
) (
   input  logic [DW-1:0] rem_in,
   input  logic          bit_in,
   input  logic [DW-1:0] divisor,
   output logic [DW-1:0] rem_out,
   output logic          q_bit
);
   import detectfaces_div_pkg::*;

   logic [DW:0] shifted;

   // The restored remainder is always below the divisor, so DW bits hold it and the
   // modular subtraction on the low DW bits is exact.
   always_comb begin
      shifted = {rem_in, bit_in};
      q_bit   = (shifted >= {1'b0, divisor});
      rem_out = q_bit ? (shifted[DW-1:0] - divisor) : shifted[DW-1:0];
   end
endmodule

// File: rtl/detectfaces_udiv_25ns_10ns_16_seq.sv
// Sequential unsigned restoring divider, 25-bit / 10-bit -> saturated 16-bit quotient.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand handshake
// CALC  | one restoring step per cycle, dividend MSB first (DIVIDEND_WIDTH cycles)
// DONE  | results registered; out_valid raised and held until out_ready
module detectfaces_udiv_25ns_10ns_16_seq #(
   parameter int DIVIDEND_WIDTH = detectfaces_div_pkg::DIVIDEND_WIDTH,
   parameter int DIVISOR_WIDTH  = detectfaces_div_pkg::DIVISOR_WIDTH,
   parameter int QUOTIENT_WIDTH = detectfaces_div_pkg::QUOTIENT_WIDTH
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [QUOTIENT_WIDTH-1:0] quotient,
   output logic [DIVISOR_WIDTH-1:0]  remainder,
   output logic                      div_by_zero,
   output logic                      overflow
);
   import detectfaces_div_pkg::*;

   localparam int CNT_W = $clog2(DIVIDEND_WIDTH);

   div_state_e                state;
   logic [CNT_W-1:0]          cnt;
   logic [DIVIDEND_WIDTH-1:0] dvd_sh;
   logic [DIVIDEND_WIDTH-1:0] fq;
   logic [DIVISOR_WIDTH-1:0]  dvs_r;
   logic [DIVISOR_WIDTH-1:0]  prem;
   logic [DIVISOR_WIDTH-1:0]  prem_nxt;
   logic                      q_bit;
   logic [DIVIDEND_WIDTH-1:0] fq_nxt;
   logic                      ovf_nxt;

   detectfaces_udiv_step #(.DW(DIVISOR_WIDTH)) u_step (
      .rem_in  (prem),
      .bit_in  (dvd_sh[DIVIDEND_WIDTH-1]),
      .divisor (dvs_r),
      .rem_out (prem_nxt),
      .q_bit   (q_bit)
   );

   // Full quotient after the current step and its saturation flag.
   always_comb begin
      fq_nxt  = (fq << 1) | DIVIDEND_WIDTH'(q_bit);
      ovf_nxt = |fq_nxt[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH];
   end

   // Control FSM, iteration counter and output registers. Results are loaded on entry
   // to DONE and out_valid follows one cycle later, giving a fixed DIVIDEND_WIDTH+1 latency.
   // Result outputs only change on that load or on reset, so they stay quiet otherwise.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         cnt         <= '0;
         dvd_sh      <= '0;
         dvs_r       <= '0;
         prem        <= '0;
         fq          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  dvd_sh   <= dividend;
                  dvs_r    <= divisor;
                  prem     <= '0;
                  fq       <= '0;
                  cnt      <= CNT_W'(DIVIDEND_WIDTH - 1);
                  in_ready <= 1'b0;
                  state    <= CALC;
               end
            end
            CALC: begin
               dvd_sh <= dvd_sh << 1;
               prem   <= prem_nxt;
               fq     <= fq_nxt;
               if (cnt == '0) begin
                  state <= DONE;
                  if (dvs_r == '0) begin
                     quotient    <= '1;
                     remainder   <= '0;
                     div_by_zero <= 1'b1;
                     overflow    <= 1'b0;
                  end else begin
                     quotient    <= ovf_nxt ? '1 : fq_nxt[QUOTIENT_WIDTH-1:0];
                     remainder   <= prem_nxt;
                     div_by_zero <= 1'b0;
                     overflow    <= ovf_nxt;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_detectfaces_udiv_25ns_10ns_16_seq.sv
// Self-checking bench for the sequential divider: directed corner cases plus random traffic.
module tb_detectfaces_udiv_25ns_10ns_16_seq;
   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [24:0] dividend = '0;
   logic [9:0]  divisor = '0;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] quotient;
   logic [9:0]  remainder;
   logic        div_by_zero;
   logic        overflow;

   detectfaces_udiv_25ns_10ns_16_seq dut (
      .ap_clk      (ap_clk),
      .ap_rst      (ap_rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 ap_clk = ~ap_clk;

   localparam int LAT = 26;

   typedef struct {
      logic [15:0] q;
      logic [9:0]  r;
      logic        dz;
      logic        ov;
   } res_t;

   int   n_checks = 0;
   int   n_fail = 0;
   bit   chk_en = 1'b0;
   bit   m_busy = 1'b0;
   int   m_age = 0;
   res_t m_exp;
   res_t m_show;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic res_t ref_div(input logic [24:0] a, input logic [9:0] b);
      res_t   r;
      longint fq;
      if (b == 0) begin
         r.q = 16'hFFFF; r.r = 0; r.dz = 1'b1; r.ov = 1'b0;
      end else begin
         fq   = longint'(a) / longint'(b);
         r.ov = (fq > 65535);
         r.q  = r.ov ? 16'hFFFF : 16'(fq);
         r.r  = 10'(longint'(a) % longint'(b));
         r.dz = 1'b0;
      end
      return r;
   endfunction

   // Reference: a busy flag and the age in edges since acceptance; results show up at age 25
   // and are announced at age LAT.
   always @(posedge ap_clk) begin
      if (ap_rst) begin
         m_busy = 1'b0;
         m_age  = 0;
         m_show.q = 0; m_show.r = 0; m_show.dz = 0; m_show.ov = 0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_exp  = ref_div(dividend, divisor);
         end
      end else if (m_age >= LAT && out_ready) begin
         m_busy = 1'b0;
      end else begin
         m_age++;
         if (m_age == LAT - 1) m_show = m_exp;
      end
   end

   always @(negedge ap_clk) begin
      if (chk_en) begin
         chk("in_ready", in_ready, !m_busy);
         chk("out_valid", out_valid, m_busy && m_age >= LAT);
         chk("quotient", quotient, m_show.q);
         chk("remainder", remainder, m_show.r);
         chk("div_by_zero", div_by_zero, m_show.dz);
         chk("overflow", overflow, m_show.ov);
      end
   end

   task automatic step();
      @(posedge ap_clk);
      #2;
   endtask

   task automatic issue(input logic [24:0] a, input logic [9:0] b);
      int n = 0;
      while (!in_ready && n < 100) begin
         step();
         n++;
      end
      chk("issue_ready_wait", in_ready, 1);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      step();
      in_valid = 1'b0;
      dividend = 25'($urandom);
      divisor  = 10'($urandom);
   endtask

   task automatic collect(input int lat0, input int hold, input res_t e);
      int lat = lat0;
      while (!out_valid && lat < 100) begin
         step();
         lat++;
      end
      chk("latency", lat, LAT);
      chk("res_quotient", quotient, e.q);
      chk("res_remainder", remainder, e.r);
      chk("res_div_by_zero", div_by_zero, e.dz);
      chk("res_overflow", overflow, e.ov);
      for (int i = 0; i < hold; i++) begin
         step();
         chk("hold_out_valid", out_valid, 1);
         chk("hold_quotient", quotient, e.q);
         chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("post_hs_in_ready", in_ready, 1);
      chk("post_hs_out_valid", out_valid, 0);
   endtask

   function automatic res_t lit(input int q, input int r, input bit dz, input bit ov);
      res_t x;
      x.q = 16'(q); x.r = 10'(r); x.dz = dz; x.ov = ov;
      return x;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [24:0] a;
      logic [9:0]  b;
      int          sel;
      step();
      chk_en = 1'b1;
      step();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_flags", {div_by_zero, overflow}, 0);
      ap_rst = 1'b0;
      step();

      issue(25'd1000, 10'd7);          collect(0, 0, lit(142, 6, 0, 0));
      issue(25'd33554431, 10'd1023);   collect(0, 0, lit(32800, 31, 0, 0));
      issue(25'd655350, 10'd10);       collect(0, 1, lit(65535, 0, 0, 0));
      issue(25'd655360, 10'd10);       collect(0, 0, lit(65535, 0, 0, 1));
      issue(25'd33554431, 10'd1);      collect(0, 2, lit(65535, 0, 0, 1));
      issue(25'd500, 10'd0);           collect(0, 0, lit(65535, 0, 1, 0));

      // Backpressure with a stray operand offer while busy.
      issue(25'd1000, 10'd7);
      repeat (4) step();
      in_valid = 1'b1; dividend = 25'd5; divisor = 10'd1;
      step();
      in_valid = 1'b0;
      collect(5, 10, lit(142, 6, 0, 0));

      // Reset during CALC discards the operation.
      issue(25'd1000, 10'd7);
      repeat (11) step();
      ap_rst = 1'b1;
      step();
      ap_rst = 1'b0;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      repeat (30) step();
      issue(25'd81, 10'd9);            collect(0, 0, lit(9, 0, 0, 0));

      for (int k = 0; k < 40; k++) begin
         a   = 25'($urandom);
         sel = $urandom_range(0, 7);
         if (sel == 0)      b = 10'd0;
         else if (sel == 1) b = 10'($urandom_range(1, 15));
         else               b = 10'($urandom_range(1, 1023));
         if (sel == 2) a = 25'($urandom_range(0, 70000));
         issue(a, b);
         collect(0, $urandom_range(0, 3), ref_div(a, b));
      end

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
